// File: rtl/trace_gen_pkg.sv
// Shared command encodings, FSM state type and header length for the trace
// stream generator.
package trace_gen_pkg;

  typedef enum logic [3:0] {
    CMD_DATA = 4'd0,
    CMD_GAP  = 4'd1,
    CMD_END  = 4'd2,
    CMD_LOOP = 4'd3
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_GAP,
    ST_DONE
  } state_e;

  // cmd nibble, count low nibble, count high nibble
  localparam int HDR_LEN = 3;

endpackage

// File: rtl/trace_cmd_mem.sv
// Nibble-wide command memory: one write port, one synchronous read port with
// a single cycle of read latency. Contents are never reset.
module trace_cmd_mem
  import trace_gen_pkg::*;
#(
  parameter int pMEM_DEPTH = 4096
) (
  input  logic                          target_clk,
  input  logic                          we,
  input  logic [$clog2(pMEM_DEPTH)-1:0] waddr,
  input  logic [3:0]                    wdata,
  input  logic [$clog2(pMEM_DEPTH)-1:0] raddr,
  output logic [3:0]                    rdata
);

  logic [3:0] mem [pMEM_DEPTH];

  always_ff @(posedge target_clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/trace_stream_gen.sv
// Plays a nibble command program out of memory onto a narrow trace port.
// Optional LOOP command support is enabled by defining TRACE_GEN_LOOP_EN.
module trace_stream_gen
  import trace_gen_pkg::*;
#(
  parameter int pPORT_WIDTH = 4,
  parameter int pMEM_DEPTH  = 4096,
  parameter int pNUM_TRIG   = 2
) (
  input  logic                          target_clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          load_we,
  input  logic [$clog2(pMEM_DEPTH)-1:0] load_addr,
  input  logic [3:0]                    load_data,
  input  logic [32*pNUM_TRIG-1:0]       trig_time,
  output logic [pPORT_WIDTH-1:0]        tracedata,
  output logic [7:0]                    sdr_byte,
  output logic                          sdr_valid,
  output logic [pNUM_TRIG-1:0]          trig_out,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);

  localparam int AW = $clog2(pMEM_DEPTH);
  localparam logic [1:0] LAST_SLICE = 2'(4 / pPORT_WIDTH - 1);
  localparam logic [1:0] LAST_PHASE = 2'(HDR_LEN - 1);

  state_e                   state_reg, state_next;
  logic [1:0]               phase_reg, phase_next;
  logic [3:0]               cmd_reg, cmd_next;
  logic [3:0]               cnt_lo_reg, cnt_lo_next;
  logic [7:0]               rem_reg, rem_next;
  logic [1:0]               slice_reg, slice_next;
  logic                     pair_reg, pair_next;
  logic [3:0]               first_nib_reg, first_nib_next;
  logic [AW-1:0]            ptr_reg, rd_addr;
  logic [pPORT_WIDTH-1:0]   tracedata_reg, tracedata_next;
  logic [7:0]               sdr_byte_reg, sdr_byte_next;
  logic                     sdr_valid_reg, sdr_valid_next;
  logic                     error_reg, error_next;
  logic [31:0]              nib_cnt_reg, nib_cnt_next;
  logic                     cnt_inc_reg, cnt_inc_next;
  logic [pNUM_TRIG-1:0]     trig_reg, trig_next;
  logic                     nib_inc, cnt_clr;
  logic [3:0]               rdata, slice_bits;
  logic [7:0]               hdr_count;
`ifdef TRACE_GEN_LOOP_EN
  logic                     loop_active_reg, loop_active_next;
  logic [7:0]               loop_left_reg, loop_left_next;
`endif

  // rdata always holds mem[ptr_reg]; rd_addr is the address wanted next cycle
  trace_cmd_mem #(.pMEM_DEPTH(pMEM_DEPTH)) u_mem (
    .target_clk (target_clk),
    .we         (load_we && !busy),
    .waddr      (load_addr),
    .wdata      (load_data),
    .raddr      (rd_addr),
    .rdata      (rdata)
  );

  assign hdr_count = {rdata, cnt_lo_reg};
  assign busy      = (state_reg == ST_HDR) || (state_reg == ST_DATA) || (state_reg == ST_GAP);
  assign done      = (state_reg == ST_DONE);
  assign tracedata = tracedata_reg;
  assign sdr_byte  = sdr_byte_reg;
  assign sdr_valid = sdr_valid_reg;
  assign trig_out  = trig_reg;
  assign error     = error_reg;

  // Fire only on the cycle after an actual counter change
  for (genvar gi = 0; gi < pNUM_TRIG; gi++) begin : g_trig
    assign trig_next[gi] = cnt_inc_reg && (trig_time[32*gi +: 32] != 32'd0)
                           && (nib_cnt_reg == trig_time[32*gi +: 32]);
  end

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    cmd_next       = cmd_reg;
    cnt_lo_next    = cnt_lo_reg;
    rem_next       = rem_reg;
    slice_next     = slice_reg;
    pair_next      = pair_reg;
    first_nib_next = first_nib_reg;
    rd_addr        = ptr_reg;
    tracedata_next = '0;
    sdr_byte_next  = sdr_byte_reg;
    sdr_valid_next = 1'b0;
    error_next     = error_reg;
    nib_inc        = 1'b0;
    cnt_clr        = 1'b0;
    nib_cnt_next   = nib_cnt_reg;
    cnt_inc_next   = 1'b0;
    slice_bits     = rdata >> (pPORT_WIDTH * int'(slice_reg));
`ifdef TRACE_GEN_LOOP_EN
    loop_active_next = loop_active_reg;
    loop_left_next   = loop_left_reg;
`endif
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start && !stop) begin
          state_next = ST_HDR;
          phase_next = '0;
          rd_addr    = '0;
          error_next = 1'b0;
          cnt_clr    = 1'b1;
`ifdef TRACE_GEN_LOOP_EN
          loop_active_next = 1'b0;
          loop_left_next   = '0;
`endif
        end
      end
      ST_HDR: begin
        rd_addr    = ptr_reg + 1'b1;
        phase_next = phase_reg + 2'd1;
        if (phase_reg == 2'd0) begin
          cmd_next = rdata;
        end else if (phase_reg != LAST_PHASE) begin
          cnt_lo_next = rdata;
        end else begin
          phase_next = '0;
          rem_next   = hdr_count;
          slice_next = '0;
          pair_next  = 1'b0;
          case (cmd_reg)
            CMD_DATA: begin
              if (cnt_lo_reg[0]) begin
                error_next = 1'b1;
                state_next = ST_DONE;
              end else if (hdr_count != 8'd0) begin
                state_next = ST_DATA;
              end
            end
            CMD_GAP:  if (hdr_count != 8'd0) state_next = ST_GAP;
            CMD_END:  state_next = ST_DONE;
`ifdef TRACE_GEN_LOOP_EN
            CMD_LOOP: begin
              if (hdr_count != 8'd0 && loop_active_reg && loop_left_reg == 8'd0) begin
                state_next = ST_DONE;
              end else begin
                rd_addr = '0;
                if (hdr_count != 8'd0) begin
                  if (loop_active_reg) begin
                    loop_left_next = loop_left_reg - 8'd1;
                  end else begin
                    loop_active_next = 1'b1;
                    loop_left_next   = hdr_count - 8'd1;
                  end
                end
              end
            end
`endif
            default: begin
              error_next = 1'b1;
              state_next = ST_DONE;
            end
          endcase
        end
      end
      ST_DATA: begin
        tracedata_next = slice_bits[pPORT_WIDTH-1:0];
        if (slice_reg == 2'd0) begin
          if (pair_reg) begin
            sdr_valid_next = 1'b1;
            sdr_byte_next  = {rdata, first_nib_reg};
          end else begin
            first_nib_next = rdata;
          end
          pair_next = !pair_reg;
        end
        if (slice_reg == LAST_SLICE) begin
          slice_next = '0;
          rd_addr    = ptr_reg + 1'b1;
          nib_inc    = 1'b1;
          rem_next   = rem_reg - 8'd1;
          if (rem_reg == 8'd1) state_next = ST_HDR;
        end else begin
          slice_next = slice_reg + 2'd1;
        end
      end
      ST_GAP: begin
        nib_inc  = 1'b1;
        rem_next = rem_reg - 8'd1;
        if (rem_reg == 8'd1) state_next = ST_HDR;
      end
      default: state_next = ST_IDLE;
    endcase

    // stop ends any active or finished playback and silences that cycle's output
    if (stop && state_reg != ST_IDLE) begin
      state_next     = ST_DONE;
      tracedata_next = '0;
      sdr_valid_next = 1'b0;
      nib_inc        = 1'b0;
      error_next     = error_reg;
    end

    if (cnt_clr) begin
      nib_cnt_next = '0;
    end else if (nib_inc && nib_cnt_reg != 32'hFFFF_FFFF) begin
      nib_cnt_next = nib_cnt_reg + 32'd1;
      cnt_inc_next = 1'b1;
    end
  end

  always_ff @(posedge target_clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      phase_reg     <= '0;
      cmd_reg       <= '0;
      cnt_lo_reg    <= '0;
      rem_reg       <= '0;
      slice_reg     <= '0;
      pair_reg      <= 1'b0;
      first_nib_reg <= '0;
      ptr_reg       <= '0;
      tracedata_reg <= '0;
      sdr_byte_reg  <= '0;
      sdr_valid_reg <= 1'b0;
      error_reg     <= 1'b0;
      nib_cnt_reg   <= '0;
      cnt_inc_reg   <= 1'b0;
      trig_reg      <= '0;
`ifdef TRACE_GEN_LOOP_EN
      loop_active_reg <= 1'b0;
      loop_left_reg   <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      cmd_reg       <= cmd_next;
      cnt_lo_reg    <= cnt_lo_next;
      rem_reg       <= rem_next;
      slice_reg     <= slice_next;
      pair_reg      <= pair_next;
      first_nib_reg <= first_nib_next;
      ptr_reg       <= rd_addr;
      tracedata_reg <= tracedata_next;
      sdr_byte_reg  <= sdr_byte_next;
      sdr_valid_reg <= sdr_valid_next;
      error_reg     <= error_next;
      nib_cnt_reg   <= nib_cnt_next;
      cnt_inc_reg   <= cnt_inc_next;
      trig_reg      <= trig_next;
`ifdef TRACE_GEN_LOOP_EN
      loop_active_reg <= loop_active_next;
      loop_left_reg   <= loop_left_next;
`endif
    end
  end

endmodule

// File: doc/trace_stream_gen.md
TRACE_STREAM_GEN -- requirements
Module: trace_stream_gen

Interface
REQ-001 SHALL have parameter pPORT_WIDTH, default 4, meaning trace port width in bits; legal values 1, 2, 4.
REQ-002 SHALL have parameter pMEM_DEPTH, default 4096, meaning command-memory depth in nibbles (power of two).
REQ-003 SHALL have parameter pNUM_TRIG, default 2, meaning number of independent trigger comparators.
REQ-004 SHALL have port target_clk  input  1  clock; all logic is in this domain.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  pulse that begins playback at address 0.
REQ-007 SHALL have port stop  input  1  pulse that ends playback and enters DONE.
REQ-008 SHALL have ports load_we (input, 1), load_addr (input, clog2(pMEM_DEPTH)) and load_data (input, 4), forming the nibble write port.
REQ-009 SHALL have port trig_time  input  32*pNUM_TRIG  packed per-trigger nibble-count match values.
REQ-010 SHALL have port tracedata  output  pPORT_WIDTH  registered trace port.
REQ-011 SHALL have ports sdr_byte (output, 8) and sdr_valid (output, 1), carrying the paired nibbles.
REQ-012 SHALL have ports trig_out (output, pNUM_TRIG), busy (output, 1), done (output, 1) and error (output, 1).

Function
REQ-013 SHALL parse the memory as records: cmd nibble, count low nibble, count high nibble (8-bit count), then payload.
REQ-014 SHALL decode cmd as 0=DATA (count payload nibbles), 1=GAP (count idle cycles), 2=END, 3=LOOP, and any other value as illegal.
REQ-015 SHALL implement the FSM states IDLE, HDR, DATA, GAP, DONE.
REQ-016 SHALL transition IDLE/DONE->HDR on start; HDR->DATA/GAP/DONE per cmd; DATA/GAP->HDR when count is exhausted; any state->DONE on stop.
REQ-017 SHALL spend exactly 3 cycles per header; start sampled at edge T puts the first data slice on tracedata at edge T+4.
REQ-018 SHALL shift each DATA nibble out LSB-first as 4/pPORT_WIDTH consecutive slices, with no bubbles between the nibbles of one record.
REQ-019 SHALL drive tracedata to 0 in every non-DATA cycle.
REQ-020 SHALL, for each nibble pair (first, second), pulse sdr_valid for one cycle with sdr_byte={second,first} in the cycle the second nibble's first slice is presented.
REQ-021 SHALL treat an odd DATA count as an error: set error (sticky) and go to DONE without emitting the record.
REQ-022 SHALL treat an illegal cmd the same way: set error and go to DONE.
REQ-023 SHALL treat a GAP record of count 0 or a DATA record of count 0 as a zero-length record: return straight to HDR.
REQ-024 SHALL keep a 32-bit nibble counter, cleared on start, incremented on the last slice of each DATA nibble and on each GAP cycle, and saturating at 0xFFFFFFFF.
REQ-025 SHALL pulse trig_out[k] for one cycle in the cycle after the counter becomes equal to trig_time[k]; a trig_time[k] of 0 never fires.
REQ-026 SHALL pulse all matching trig_out bits together when several triggers match in the same cycle.
REQ-027 SHALL assert done on entering DONE and hold it until the next start; busy SHALL be high in HDR, DATA and GAP.
REQ-028 SHALL ignore start while busy; stop beats start in the same cycle; stop while IDLE has no effect.
REQ-029 SHALL ignore load_we while busy, and when not busy SHALL write the memory in the cycle load_we is sampled.
REQ-030 SHALL wrap the read address from pMEM_DEPTH-1 to 0 and continue parsing.

Reset
REQ-031 SHALL clear, while reset is low, the FSM to IDLE and tracedata, sdr_byte, sdr_valid, trig_out, busy, done, error and the nibble counter to 0, including mid-playback; memory contents are not reset.
REQ-032 SHALL clear error only on reset or on start.

Configuration
REQ-033 SHALL, with TRACE_GEN_LOOP_EN defined, make LOOP with count N restart parsing at address 0 N further times (nibble counter not cleared), make count 0 loop until stop, and treat LOOP as END once the passes are exhausted.
REQ-034 SHALL, without TRACE_GEN_LOOP_EN, treat cmd 3 as illegal per REQ-022.

Structure
REQ-035 SHALL place the cmd encodings, the FSM state enum and the header length constant in package trace_gen_pkg.
REQ-036 SHALL implement the nibble memory as sub-module trace_cmd_mem: 1 write port, 1 synchronous read port, 1-cycle read latency.

Verification
REQ-037 SHALL show, with W=4, record 0,4,0,A,B,C,D then 2, and start at T: tracedata A,B,C,D at T+4..T+7; sdr_valid with 0xBA at T+5 and 0xDC at T+7; done set.
REQ-038 SHALL show, with W=1, nibble 0x5 producing tracedata 1,0,1,0 over 4 cycles and the counter reaching 1 on the 4th cycle.
REQ-039 SHALL show GAP count 0x10 followed by END with trig_time[0]=16 giving trig_out[0] exactly once and tracedata 0 throughout.
REQ-040 SHALL show a DATA record of count 3 setting error and done, with tracedata held at 0.
REQ-041 SHALL show, with TRACE_GEN_LOOP_EN, DATA 2 nibbles plus LOOP count 2 emitting 6 nibbles with the counter at 6; without the macro, error is set.
REQ-042 SHALL show reset asserted mid-DATA returning all outputs to 0 asynchronously, and a following start replaying from address 0.
